// File: rtl/calc_sequencer.sv
// Calculator operation sequencer: operand/operator entry with wrap-around editing,
// single-cycle add/sub, iterative shift-add multiply and restoring divide.
module calc_sequencer #(
  parameter int unsigned OPW    = 7,
  parameter int unsigned RESW   = 13,
  parameter int unsigned MAXVAL = 99
) (
  input  logic            masCLK,
  input  logic            Reset,
  input  logic            Plus,
  input  logic            Minus,
  input  logic            Next,
  input  logic            Clear,
  output logic [OPW-1:0]  operand_a,
  output logic [OPW-1:0]  operand_b,
  output logic [1:0]      op_code,
  output logic [RESW-1:0] result,
  output logic            neg,
  output logic            err,
  output logic            busy,
  output logic            done,
  output logic [1:0]      disp_sel
);

  localparam int unsigned    CW      = $clog2(OPW + 1);
  localparam logic [2:0]     ENTER_A  = 3'd0;
  localparam logic [2:0]     ENTER_B  = 3'd1;
  localparam logic [2:0]     ENTER_OP = 3'd2;
  localparam logic [2:0]     COMPUTE  = 3'd3;
  localparam logic [2:0]     SHOW     = 3'd4;
  localparam logic [1:0]     OP_ADD   = 2'd0;
  localparam logic [1:0]     OP_SUB   = 2'd1;
  localparam logic [1:0]     OP_MUL   = 2'd2;
  localparam logic [1:0]     OP_DIV   = 2'd3;
  localparam logic [OPW-1:0] MAX_V    = OPW'(MAXVAL);
  localparam logic [CW-1:0]  LAST_IT  = CW'(OPW - 1);

  logic [2:0]      state;
  logic            plus_q, minus_q, next_q, clear_q;
  logic            plus_r, minus_r, next_r, clear_r;
  logic            step_up, step_dn;
  logic [RESW-1:0] acc;
  logic [RESW-1:0] mcand;
  logic [OPW-1:0]  shreg;
  logic [CW-1:0]   iter;
  logic [RESW-1:0] mul_sum, sum_ab, diff_ab;
  logic [OPW:0]    rem_sh;
  logic            div_ok;
  logic [OPW-1:0]  new_rem, new_quo;
  logic            b_zero, last_cycle;

  assign plus_r  = Plus  & ~plus_q;
  assign minus_r = Minus & ~minus_q;
  assign next_r  = Next  & ~next_q;
  assign clear_r = Clear & ~clear_q;
  assign step_up = plus_r & ~minus_r;
  assign step_dn = minus_r & ~plus_r;

  function automatic logic [OPW-1:0] edit_value(input logic [OPW-1:0] v,
                                                input logic up, input logic dn);
    if (up) return (v == MAX_V) ? '0 : v + OPW'(1);
    if (dn) return (v == '0) ? MAX_V : v - OPW'(1);
    return v;
  endfunction

  // Multiply: acc += mcand when the current multiplier LSB is set, mcand shifts left.
  // Divide: shreg holds the dividend shifting out MSB-first and collects quotient bits;
  // acc[OPW-1:0] holds the partial remainder.
  always_comb begin
    mul_sum    = acc + (shreg[0] ? mcand : '0);
    sum_ab     = RESW'(operand_a) + RESW'(operand_b);
    diff_ab    = (operand_a >= operand_b) ? RESW'(operand_a - operand_b)
                                          : RESW'(operand_b - operand_a);
    rem_sh     = {acc[OPW-1:0], shreg[OPW-1]};
    div_ok     = (rem_sh >= {1'b0, operand_b});
    new_rem    = div_ok ? OPW'(rem_sh - {1'b0, operand_b}) : rem_sh[OPW-1:0];
    new_quo    = {shreg[OPW-2:0], div_ok};
    b_zero     = (operand_b == '0);
    last_cycle = (iter == LAST_IT);
    if (op_code == OP_ADD || op_code == OP_SUB) last_cycle = 1'b1;
    else if (op_code == OP_DIV && b_zero)       last_cycle = 1'b1;
  end

  assign busy = (state == COMPUTE);
  assign done = busy & last_cycle & ~clear_r;

  always_comb begin
    case (state)
      ENTER_A:  disp_sel = 2'd0;
      ENTER_B:  disp_sel = 2'd1;
      ENTER_OP: disp_sel = 2'd1;
      COMPUTE:  disp_sel = 2'd2;
      SHOW:     disp_sel = err ? 2'd3 : 2'd2;
      default:  disp_sel = 2'd0;
    endcase
  end

  always_ff @(posedge masCLK or negedge Reset) begin
    if (!Reset) begin
      state     <= ENTER_A;
      plus_q    <= 1'b0;
      minus_q   <= 1'b0;
      next_q    <= 1'b0;
      clear_q   <= 1'b0;
      operand_a <= '0;
      operand_b <= '0;
      op_code   <= '0;
      result    <= '0;
      neg       <= 1'b0;
      err       <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      shreg     <= '0;
      iter      <= '0;
    end else begin
      plus_q  <= Plus;
      minus_q <= Minus;
      next_q  <= Next;
      clear_q <= Clear;
      if (clear_r) begin
        state     <= ENTER_A;
        operand_a <= '0;
        operand_b <= '0;
        op_code   <= '0;
        result    <= '0;
        neg       <= 1'b0;
        err       <= 1'b0;
        iter      <= '0;
      end else begin
        case (state)
          ENTER_A: begin
            if (next_r) state <= ENTER_B;
            else        operand_a <= edit_value(operand_a, step_up, step_dn);
          end
          ENTER_B: begin
            if (next_r) state <= ENTER_OP;
            else        operand_b <= edit_value(operand_b, step_up, step_dn);
          end
          ENTER_OP: begin
            if (next_r) begin
              state <= COMPUTE;
              err   <= 1'b0;
              neg   <= 1'b0;
              acc   <= '0;
              mcand <= RESW'(operand_a);
              shreg <= (op_code == OP_DIV) ? operand_a : operand_b;
              iter  <= '0;
            end else if (step_up) begin
              op_code <= op_code + 2'd1;
            end else if (step_dn) begin
              op_code <= op_code - 2'd1;
            end
          end
          COMPUTE: begin
            case (op_code)
              OP_ADD: begin
                result <= sum_ab;
                state  <= SHOW;
              end
              OP_SUB: begin
                result <= diff_ab;
                neg    <= (operand_b > operand_a);
                state  <= SHOW;
              end
              OP_MUL: begin
                if (last_cycle) begin
                  result <= mul_sum;
                  state  <= SHOW;
                end else begin
                  acc   <= mul_sum;
                  mcand <= mcand << 1;
                  shreg <= shreg >> 1;
                  iter  <= iter + CW'(1);
                end
              end
              default: begin
                if (b_zero) begin
                  err    <= 1'b1;
                  result <= '0;
                  state  <= SHOW;
                end else if (last_cycle) begin
                  result <= RESW'(new_quo);
                  state  <= SHOW;
                end else begin
                  acc   <= RESW'(new_rem);
                  shreg <= new_quo;
                  iter  <= iter + CW'(1);
                end
              end
            endcase
          end
          SHOW: begin
            if (next_r) state <= ENTER_A;
          end
          default: state <= ENTER_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: randomized entry and operations
// compared against an arithmetic reference model of the calculator.
module tb_calc_sequencer;

  // 14 result bits so that 99*99 = 9801 is representable
  localparam int unsigned OPW    = 7;
  localparam int unsigned RESW   = 14;
  localparam int unsigned MAXVAL = 99;

  logic            masCLK = 1'b0;
  logic            Reset  = 1'b0;
  logic            Plus   = 1'b0;
  logic            Minus  = 1'b0;
  logic            Next   = 1'b0;
  logic            Clear  = 1'b0;
  logic [OPW-1:0]  operand_a, operand_b;
  logic [1:0]      op_code;
  logic [RESW-1:0] result;
  logic            neg, err, busy, done;
  logic [1:0]      disp_sel;

  calc_sequencer #(.OPW(OPW), .RESW(RESW), .MAXVAL(MAXVAL)) dut (
    .masCLK(masCLK), .Reset(Reset), .Plus(Plus), .Minus(Minus), .Next(Next),
    .Clear(Clear), .operand_a(operand_a), .operand_b(operand_b), .op_code(op_code),
    .result(result), .neg(neg), .err(err), .busy(busy), .done(done), .disp_sel(disp_sel)
  );

  always #5 masCLK = ~masCLK;

  int passed = 0;
  int total  = 0;

  typedef enum {PH_A, PH_B, PH_OP, PH_CALC, PH_SHOW} phase_t;
  phase_t ph;
  int m_a, m_b, m_op, m_res;
  bit m_neg, m_err;

  function automatic int wrap_step(int v, bit up);
    if (up) return (v == MAXVAL) ? 0 : v + 1;
    return (v == 0) ? MAXVAL : v - 1;
  endfunction

  function automatic int ref_result(int a, int b, int op);
    case (op)
      0:       return a + b;
      1:       return (a >= b) ? a - b : b - a;
      2:       return (a * b) % (1 << RESW);
      default: return (b == 0) ? 0 : a / b;
    endcase
  endfunction

  function automatic int ref_latency(int b, int op);
    if (op < 2 || (op == 3 && b == 0)) return 1;
    return OPW;
  endfunction

  function automatic int exp_disp();
    case (ph)
      PH_A:    return 0;
      PH_B:    return 1;
      PH_OP:   return 1;
      PH_CALC: return 2;
      default: return m_err ? 3 : 2;
    endcase
  endfunction

  function automatic logic [2*OPW+RESW+7:0] all_outs();
    return {operand_a, operand_b, op_code, result, neg, err, busy, done, disp_sel};
  endfunction

  task automatic model_zero();
    ph = PH_A; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_neg = 0; m_err = 0;
  endtask

  task automatic model_rise(bit p, bit m, bit n, bit c);
    if (c) model_zero();
    else if (n) begin
      case (ph)
        PH_A:    ph = PH_B;
        PH_B:    ph = PH_OP;
        PH_OP:   begin ph = PH_CALC; m_neg = 0; m_err = 0; end
        PH_SHOW: ph = PH_A;
        default: ;
      endcase
    end else if (p != m) begin
      case (ph)
        PH_A:    m_a = wrap_step(m_a, p);
        PH_B:    m_b = wrap_step(m_b, p);
        PH_OP:   m_op = (m_op + (p ? 1 : 3)) % 4;
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge masCLK);
    #1;
  endtask

  // One idle cycle so every press is a fresh rise, then the inputs for one edge.
  task automatic press(bit p, bit m, bit n, bit c);
    cycle();
    Plus = p; Minus = m; Next = n; Clear = c;
    cycle();
    model_rise(p, m, n, c);
    Plus = 0; Minus = 0; Next = 0; Clear = 0;
  endtask

  task automatic set_operand(int v);
    if (v <= (MAXVAL + 1) / 2) repeat (v) press(1, 0, 0, 0);
    else repeat (MAXVAL + 1 - v) press(0, 1, 0, 0);
  endtask

  task automatic enter_calc(int a, int b, int op);
    press(0, 0, 0, 1);
    set_operand(a);
    press(0, 0, 1, 0);
    set_operand(b);
    press(0, 0, 1, 0);
    if (op == 3) press(0, 1, 0, 0);
    else repeat (op) press(1, 0, 0, 0);
    press(0, 0, 1, 0);
  endtask

  task automatic run_calc(int a, int b, int op, string tag);
    int exp_res, lat, k, got;
    bit stable;
    enter_calc(a, b, op);
    total++;
    if ({operand_a, operand_b, op_code} !== {OPW'(m_a), OPW'(m_b), 2'(m_op)}) begin
      $display("FAIL %s entry: got a=%0d b=%0d op=%0d expected a=%0d b=%0d op=%0d",
               tag, operand_a, operand_b, op_code, m_a, m_b, m_op);
    end else passed++;
    total++;
    if ({busy, err, neg, disp_sel} !== {1'b1, 1'b0, 1'b0, 2'd2}) begin
      $display("FAIL %s compute_entry: got busy=%b err=%b neg=%b disp=%0d expected 1 0 0 2",
               tag, busy, err, neg, disp_sel);
    end else passed++;
    exp_res = ref_result(m_a, m_b, m_op);
    lat     = ref_latency(m_b, m_op);
    stable  = 1;
    got     = 0;
    k       = 1;
    while (k <= 20) begin
      if (result !== RESW'(m_res)) stable = 0;
      if (done === 1'b1) begin
        got = k;
        break;
      end
      cycle();
      k++;
    end
    total++;
    if (got != lat) $display("FAIL %s latency: got %0d cycles expected %0d", tag, got, lat);
    else passed++;
    total++;
    if (!stable) $display("FAIL %s result_hold: result=%0d changed before done expected %0d",
                          tag, result, m_res);
    else passed++;
    cycle();
    ph    = PH_SHOW;
    m_res = exp_res;
    m_neg = (m_op == 1 && m_b > m_a);
    m_err = (m_op == 3 && m_b == 0);
    total++;
    if (result !== RESW'(m_res)) $display("FAIL %s result: got %0d expected %0d", tag, result, m_res);
    else passed++;
    total++;
    if ({neg, err} !== {m_neg, m_err})
      $display("FAIL %s flags: got neg=%b err=%b expected neg=%b err=%b", tag, neg, err, m_neg, m_err);
    else passed++;
    total++;
    if ({busy, done, disp_sel} !== {1'b0, 1'b0, 2'(exp_disp())})
      $display("FAIL %s show: got busy=%b done=%b disp=%0d expected 0 0 %0d",
               tag, busy, done, disp_sel, exp_disp());
    else passed++;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (all_outs() !== '0) $display("FAIL reset_outputs: got %h expected 0", all_outs());
    else passed++;
    cycle();
    Reset = 1;
    model_zero();
    cycle();
    total++;
    if (all_outs() !== '0) $display("FAIL reset_release: got %h expected 0", all_outs());
    else passed++;
  endtask

  task automatic test_wrap();
    int v;
    press(0, 0, 0, 1);
    press(0, 1, 0, 0);
    total++;
    if (operand_a !== OPW'(m_a) || m_a != MAXVAL)
      $display("FAIL wrap_down: got %0d expected %0d", operand_a, MAXVAL);
    else passed++;
    press(1, 0, 0, 0);
    total++;
    if (operand_a !== '0) $display("FAIL wrap_up: got %0d expected 0", operand_a);
    else passed++;
    v = $urandom_range(1, MAXVAL - 1);
    set_operand(v);
    press(1, 1, 0, 0);
    total++;
    if (operand_a !== OPW'(v)) $display("FAIL plus_minus_cancel: got %0d expected %0d", operand_a, v);
    else passed++;
    cycle();
    Plus = 1;
    repeat (5) cycle();
    Plus = 0;
    model_rise(1, 0, 0, 0);
    total++;
    if (operand_a !== OPW'(m_a)) $display("FAIL held_plus: got %0d expected %0d", operand_a, m_a);
    else passed++;
    for (int i = 0; i < 25; i++) begin
      press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
      total++;
      if (operand_a !== OPW'(m_a)) $display("FAIL random_edit_a: got %0d expected %0d", operand_a, m_a);
      else passed++;
    end
    press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    total++;
    if ({operand_b, disp_sel} !== {OPW'(m_b), 2'(exp_disp())})
      $display("FAIL wrap_b: got b=%0d disp=%0d expected b=%0d disp=%0d", operand_b, disp_sel, m_b, exp_disp());
    else passed++;
    press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    total++;
    if (op_code !== 2'(m_op)) $display("FAIL op_wrap_down: got %0d expected %0d", op_code, m_op);
    else passed++;
    press(1, 0, 0, 0);
    total++;
    if (op_code !== 2'(m_op)) $display("FAIL op_wrap_up: got %0d expected %0d", op_code, m_op);
    else passed++;
  endtask

  task automatic test_add_sub();
    run_calc(45, 54, 0, "add_45_54");
    run_calc(12, 30, 1, "sub_12_30");
    for (int i = 0; i < 3; i++)
      run_calc($urandom_range(0, MAXVAL), $urandom_range(0, MAXVAL), i % 2, "rand_addsub");
  endtask

  task automatic test_mul_div();
    run_calc(99, 99, 2, "mul_99_99");
    run_calc(99, 7, 3, "div_99_7");
    for (int i = 0; i < 3; i++) begin
      run_calc($urandom_range(0, MAXVAL), $urandom_range(0, MAXVAL), 2, "rand_mul");
      run_calc($urandom_range(0, MAXVAL), $urandom_range(1, MAXVAL), 3, "rand_div");
    end
  endtask

  task automatic test_div_zero();
    run_calc(5, 0, 3, "div0");
    press(0, 0, 1, 0);
    total++;
    if ({err, disp_sel, operand_a, result} !== {1'b1, 2'(exp_disp()), OPW'(m_a), RESW'(m_res)})
      $display("FAIL div0_next: got err=%b disp=%0d a=%0d res=%0d expected 1 %0d %0d %0d",
               err, disp_sel, operand_a, result, exp_disp(), m_a, m_res);
    else passed++;
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    total++;
    if ({busy, err, done} !== {1'b1, 1'b0, 1'b1})
      $display("FAIL div0_recompute: got busy=%b err=%b done=%b expected 1 0 1", busy, err, done);
    else passed++;
    cycle();
    ph = PH_SHOW;
    m_res = ref_result(m_a, m_b, m_op);
    total++;
    if ({result, disp_sel} !== {RESW'(m_res), 2'(exp_disp())})
      $display("FAIL div0_after_add: got res=%0d disp=%0d expected %0d %0d", result, disp_sel, m_res, exp_disp());
    else passed++;
  endtask

  task automatic test_show_ignores();
    run_calc($urandom_range(1, MAXVAL), $urandom_range(1, MAXVAL), 0, "show_setup");
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    total++;
    if ({operand_a, operand_b, result, disp_sel} !== {OPW'(m_a), OPW'(m_b), RESW'(m_res), 2'(exp_disp())})
      $display("FAIL show_ignore_edit: got a=%0d b=%0d res=%0d disp=%0d expected %0d %0d %0d %0d",
               operand_a, operand_b, result, disp_sel, m_a, m_b, m_res, exp_disp());
    else passed++;
    press(0, 0, 1, 0);
    total++;
    if ({operand_a, operand_b, result, disp_sel} !== {OPW'(m_a), OPW'(m_b), RESW'(m_res), 2'(exp_disp())})
      $display("FAIL show_next: got a=%0d b=%0d res=%0d disp=%0d expected %0d %0d %0d %0d",
               operand_a, operand_b, result, disp_sel, m_a, m_b, m_res, exp_disp());
    else passed++;
  endtask

  task automatic test_clear_mid_mul();
    bit saw_done;
    enter_calc(99, 99, 2);
    cycle();
    cycle();
    Clear = 1;
    #1;
    saw_done = (done === 1'b1);
    cycle();
    Clear = 0;
    model_zero();
    total++;
    if (all_outs() !== '0) $display("FAIL clear_mid_mul: got %h expected 0", all_outs());
    else passed++;
    repeat (8) begin
      if (done !== 1'b0) saw_done = 1;
      cycle();
    end
    total++;
    if (saw_done) $display("FAIL clear_no_done: got done=1 expected 0");
    else passed++;
    run_calc($urandom_range(0, MAXVAL), $urandom_range(0, MAXVAL), 2, "after_clear");
  endtask

  task automatic test_reset_mid_run();
    press(0, 0, 0, 1);
    set_operand(3);
    press(0, 0, 1, 0);
    set_operand(2);
    Reset = 0;
    #2;
    total++;
    if (all_outs() !== '0) $display("FAIL async_reset: got %h expected 0", all_outs());
    else passed++;
    cycle();
    Reset = 1;
    model_zero();
    cycle();
    total++;
    if (all_outs() !== '0) $display("FAIL reset_mid_release: got %h expected 0", all_outs());
    else passed++;
    run_calc($urandom_range(0, MAXVAL), $urandom_range(0, MAXVAL), $urandom_range(0, 3), "after_reset");
  endtask

  initial begin
    model_zero();
    test_reset();
    test_wrap();
    test_add_sub();
    test_mul_div();
    test_div_zero();
    test_show_ignores();
    test_clear_mid_mul();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
